// File: rtl/arena_scanner.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : arena_scanner
//  Description : Snapshots a wall bitmap and two bomb-phase bitmaps on start,
//                then streams every grid cell in row-major order over a
//                valid/ready handshake. Each cell carries a 2-bit code:
//                0 empty, 1 arena, 2 bomb phase 0, 3 bomb phase 1.
//                nonempty_cnt reports the number of non-empty cells in the
//                last completed frame.
//  Optional    : define SCAN_SKIP_EMPTY_EN to suppress empty cells. Each empty
//                cell is stepped over in one cycle with cell_valid low.
//  Ports       : clk, rst_n (async, active low)
//                arena_0, bombs_0, bombs_1 : ROWS*COLS-bit bitmaps, row*COLS+col
//                start        : begin a frame (ignored while busy)
//                out_ready    : consumer accepts the current cell
//                cell_valid, cell_row, cell_col, cell_code : current cell
//                busy         : high in SCAN and DONE
//                done         : one-cycle end-of-frame pulse
//                nonempty_cnt : non-empty cell count of the last frame
//  Revision    : 1.0 - initial release
// ============================================================================
module arena_scanner #(
    parameter int ROWS = 10,
    parameter int COLS = 10
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [ROWS*COLS-1:0]   arena_0,
    input  logic [ROWS*COLS-1:0]   bombs_0,
    input  logic [ROWS*COLS-1:0]   bombs_1,
    input  logic                   start,
    input  logic                   out_ready,
    output logic                   cell_valid,
    output logic [3:0]             cell_row,
    output logic [3:0]             cell_col,
    output logic [1:0]             cell_code,
    output logic                   busy,
    output logic                   done,
    output logic [6:0]             nonempty_cnt
);

    localparam int c_cells = ROWS * COLS;
    localparam int c_iw    = $clog2(c_cells);

    localparam logic [1:0] c_st_idle = 2'd0;
    localparam logic [1:0] c_st_scan = 2'd1;
    localparam logic [1:0] c_st_done = 2'd2;

    logic [1:0]          r_state;
    logic [1:0]          w_next_state;

    logic [c_cells-1:0]  r_snap_a;
    logic [c_cells-1:0]  r_snap_b0;
    logic [c_cells-1:0]  r_snap_b1;

    // Linear index is kept alongside row/col so the bitmap lookup needs no
    // multiplier.
    logic [c_iw-1:0]     r_idx;
    logic [3:0]          r_row;
    logic [3:0]          r_col;
    logic [6:0]          r_cnt;
    logic [6:0]          r_nonempty_cnt;

    logic [1:0]          w_code;
    logic                w_present;
    logic                w_adv;
    logic                w_last;
    logic                w_inc;

    // Bomb phase 1 outranks phase 0, which outranks the wall bit.
    always_comb begin
        w_code = 2'd0;
        if (r_snap_b1[r_idx])
            w_code = 2'd3;
        else if (r_snap_b0[r_idx])
            w_code = 2'd2;
        else if (r_snap_a[r_idx])
            w_code = 2'd1;
    end

`ifdef SCAN_SKIP_EMPTY_EN
    assign w_present = (w_code != 2'd0);
`else
    assign w_present = 1'b1;
`endif

    // A cell that is not presented advances on its own; a presented cell
    // advances only on handshake.
    assign w_adv  = (r_state == c_st_scan) && (!w_present || out_ready);
    assign w_last = (r_idx == c_iw'(c_cells - 1));
    // Non-empty cells are always presented, so this counts handshakes only.
    assign w_inc  = w_adv && (w_code != 2'd0);

    // ---------------- state register ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_state <= c_st_idle;
        else
            r_state <= w_next_state;
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_st_idle: if (start) w_next_state = c_st_scan;
            c_st_scan: if (w_adv && w_last) w_next_state = c_st_done;
            c_st_done: w_next_state = c_st_idle;
            default:   w_next_state = c_st_idle;
        endcase
    end

    // ---------------- output logic ----------------
    always_comb begin
        cell_valid = 1'b0;
        cell_code  = 2'd0;
        busy       = 1'b0;
        done       = 1'b0;
        case (r_state)
            c_st_scan: begin
                cell_valid = w_present;
                cell_code  = w_code;
                busy       = 1'b1;
            end
            c_st_done: begin
                busy = 1'b1;
                done = 1'b1;
            end
            default: ;
        endcase
    end

    assign cell_row     = r_row;
    assign cell_col     = r_col;
    assign nonempty_cnt = r_nonempty_cnt;

    // ---------------- datapath ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_snap_a       <= '0;
            r_snap_b0      <= '0;
            r_snap_b1      <= '0;
            r_idx          <= '0;
            r_row          <= 4'd0;
            r_col          <= 4'd0;
            r_cnt          <= 7'd0;
            r_nonempty_cnt <= 7'd0;
        end else if (r_state == c_st_idle && start) begin
            r_snap_a  <= arena_0;
            r_snap_b0 <= bombs_0;
            r_snap_b1 <= bombs_1;
            r_idx     <= '0;
            r_row     <= 4'd0;
            r_col     <= 4'd0;
            r_cnt     <= 7'd0;
        end else if (w_adv) begin
            r_cnt <= r_cnt + 7'(w_inc);
            if (w_last) begin
                // Final cell's contribution lands in the reported count.
                r_nonempty_cnt <= r_cnt + 7'(w_inc);
                r_idx          <= '0;
                r_row          <= 4'd0;
                r_col          <= 4'd0;
            end else begin
                r_idx <= r_idx + 1'b1;
                if (r_col == 4'(COLS - 1)) begin
                    r_col <= 4'd0;
                    r_row <= r_row + 4'd1;
                end else begin
                    r_col <= r_col + 4'd1;
                end
            end
        end
    end

endmodule
`default_nettype wire
